reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised successor to the core's general-purpose register file.
- Configurable data width, register count and read-port count.
- Two write ports: WB0 for single-cycle ALU writeback, WB1 for long-latency load/MUL writeback.
- Per-register pending scoreboard so the decode stage can stall on in-flight destinations.
- Sits between decode (reads, reserve) and the writeback stage(s).

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 32, number of architectural registers (power of two, >=2); AW = $clog2(DEPTH).
- NUM_RD, 2, number of combinational read ports.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd_addr_i  input  NUM_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data_o  output  NUM_RD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH].
- rd_busy_o  output  NUM_RD  1 = addressed register has a pending write.
- wb0_en_i  input  1  write-port-0 enable.
- wb0_addr_i  input  AW  write-port-0 address.
- wb0_data_i  input  WIDTH  write-port-0 data.
- wb1_en_i  input  1  write-port-1 enable.
- wb1_addr_i  input  AW  write-port-1 address.
- wb1_data_i  input  WIDTH  write-port-1 data.
- rsv_en_i  input  1  reserve destination (set pending).
- rsv_addr_i  input  AW  register to reserve.
- pending_o  output  DEPTH  full pending vector, bit i = register i.

Behaviour:
- Reset (async, rst=1):
  - All registers 1..DEPTH-1 clear to 0; all pending bits clear.
  - rd_data_o = 0, rd_busy_o = 0, pending_o = 0 while rst is held.
  - Reset asserted mid-operation discards any write or reserve in that cycle.
- Register 0:
  - Reads always return 0; writes to address 0 are ignored.
  - Never becomes pending; pending_o[0] and the corresponding rd_busy_o bit are always 0.
  - Storage for r0 is not required.
- Reads:
  - Combinational, 0-cycle latency from rd_addr_i.
  - Return the stored value, i.e. the value before the current edge's write.
  - Write-through behaviour is covered only under the optional feature.
- Writes:
  - Take effect at the rising edge when the port's enable is 1; 1-cycle latency to visibility.
- Write collision (both ports enabled, same non-zero address): WB1 data is stored.
  - WB1 carries the older long-latency result only by program order; the decode stall guarantees that no WAW pair reaches both ports in the same cycle.
  - The collision rule is therefore defined for determinism only.
- Scoreboard, per register i != 0, next-state priority (highest first):
  1. rsv_en_i && rsv_addr_i==i -> pending set to 1.
  2. (wb0_en_i && wb0_addr_i==i) || (wb1_en_i && wb1_addr_i==i) -> pending cleared to 0.
  3. Otherwise hold.
- Simultaneous reserve and writeback to the same register: reserve wins, so pending stays 1 and a new op is in flight. The write data is still stored.
- Reserving an already-pending register keeps it at 1. No counting: one outstanding writer per register is guaranteed by the decode stall.
- A writeback to a non-pending register is legal: data is stored and pending stays 0.
- rd_busy_o[k] = pending[rd_addr k], combinational.
- No handshake back-pressure: every enabled write completes in its cycle.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined:
  - Read port k whose address matches an enabled, non-zero write address in the same cycle returns that write data (WB1 over WB0 on collision).
  - rd_busy_o[k] is forced to 0 for that read, unless rsv_en_i targets the same address in that cycle.
  - Adds one comparator and mux per read port per write port.
- Undefined:
  - Reads return the stored value only; busy reflects the registered pending bit.
  - Pure registered behaviour, identical to the description above.

Test Plan:
1. Reset then read: rst=1 for 2 cycles, release, read r5 and r31 -> rd_data_o=0 and rd_busy_o=0 on both ports; pending_o=0.
2. r0 hardwire: WB0 write 0xDEADBEEF to r0, reserve r0, read r0 next cycle -> data 0, busy 0, pending_o[0]=0.
3. Basic write/read: WB0 write 0x12345678 to r7 -> same cycle reads the old value (bypass off) or 0x12345678 (bypass on); next cycle reads 0x12345678 on every port.
4. Scoreboard lifecycle: reserve r3 at cycle n -> busy for r3 =1 from n+1; WB1 writes 0xA5A5A5A5 to r3 at cycle n+4 -> busy=0 and data=0xA5A5A5A5 from n+5.
5. Simultaneous events on r9:
   - Reserve r9 and WB0 write 0x1 to r9 in the same cycle -> pending[9]=1, stored value 0x1.
   - Separately, WB0=0x11 and WB1=0x22 both to r4 -> r4 reads 0x22.
6. Async reset mid-operation: r10 pending with value 0x55; assert rst between clock edges -> pending_o and r10 clear immediately, without waiting for a clock edge; a write enabled in the reset cycle is not stored.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised register file with two writeback ports and a per-register pending scoreboard.
// Optional same-cycle write-to-read forwarding is enabled with `define REG_FILE_BYPASS_EN.
module reg_file_sb #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 32,
   parameter int NUM_RD = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_RD*AW-1:0]    rd_addr_i,
   output logic [NUM_RD*WIDTH-1:0] rd_data_o,
   output logic [NUM_RD-1:0]       rd_busy_o,
   input  logic                    wb0_en_i,
   input  logic [AW-1:0]           wb0_addr_i,
   input  logic [WIDTH-1:0]        wb0_data_i,
   input  logic                    wb1_en_i,
   input  logic [AW-1:0]           wb1_addr_i,
   input  logic [WIDTH-1:0]        wb1_data_i,
   input  logic                    rsv_en_i,
   input  logic [AW-1:0]           rsv_addr_i,
   output logic [DEPTH-1:0]        pending_o
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pending;

   // Entry 0 is only ever cleared, so it folds to constant zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         pending <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (wb1_en_i && wb1_addr_i == AW'(i))
               regs[i] <= wb1_data_i;
            else if (wb0_en_i && wb0_addr_i == AW'(i))
               regs[i] <= wb0_data_i;

            if (rsv_en_i && rsv_addr_i == AW'(i))
               pending[i] <= 1'b1;
            else if ((wb0_en_i && wb0_addr_i == AW'(i)) ||
                     (wb1_en_i && wb1_addr_i == AW'(i)))
               pending[i] <= 1'b0;
         end
      end
   end

   assign pending_o = {pending[DEPTH-1:1], 1'b0};

   always_comb begin
      rd_data_o = '0;
      rd_busy_o = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         logic [AW-1:0]    a;
         logic [WIDTH-1:0] d;
         logic             b;
         a = rd_addr_i[k*AW +: AW];
         d = regs[a];
         b = pending[a];
`ifdef REG_FILE_BYPASS_EN
         // Forwarded reads are not busy unless the same cycle re-reserves the register.
         if (wb0_en_i && wb0_addr_i == a) begin
            d = wb0_data_i;
            b = rsv_en_i && rsv_addr_i == a;
         end
         if (wb1_en_i && wb1_addr_i == a) begin
            d = wb1_data_i;
            b = rsv_en_i && rsv_addr_i == a;
         end
`endif
         if (a == '0 || rst) begin
            d = '0;
            b = 1'b0;
         end
         rd_data_o[k*WIDTH +: WIDTH] = d;
         rd_busy_o[k]                = b;
      end
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: expectations are queued as stimulus is applied
// and popped against the read ports; a reference model covers the random phase.
module tb_reg_file_sb;
   localparam int W  = 32;
   localparam int D  = 32;
   localparam int NR = 2;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*W-1:0]  rd_data;
   logic [NR-1:0]    rd_busy;
   logic             wb0_en, wb1_en, rsv_en;
   logic [AW-1:0]    wb0_addr, wb1_addr, rsv_addr;
   logic [W-1:0]     wb0_data, wb1_data;
   logic [D-1:0]     pending;

   always #5 clk = ~clk;

   reg_file_sb #(.WIDTH(W), .DEPTH(D), .NUM_RD(NR)) dut (
      .clk(clk), .rst(rst),
      .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
      .wb0_en_i(wb0_en), .wb0_addr_i(wb0_addr), .wb0_data_i(wb0_data),
      .wb1_en_i(wb1_en), .wb1_addr_i(wb1_addr), .wb1_data_i(wb1_data),
      .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .pending_o(pending)
   );

   typedef struct {
      string        name;
      int           port;
      logic [W-1:0] data;
      logic         busy;
   } exp_t;

   exp_t         sbq[$];
   int           n_chk  = 0;
   int           n_pass = 0;
   logic [W-1:0] mreg [D];
   logic [D-1:0] mpend;

   task automatic push(input string nm, input int port, input logic [W-1:0] d, input logic b);
      exp_t e;
      e.name = nm; e.port = port; e.data = d; e.busy = b;
      sbq.push_back(e);
   endtask

   task automatic idle();
      wb0_en = 0; wb1_en = 0; rsv_en = 0;
      wb0_addr = '0; wb1_addr = '0; rsv_addr = '0;
      wb0_data = '0; wb1_data = '0;
   endtask

   task automatic set_rd(input int k, input logic [AW-1:0] a);
      rd_addr[k*AW +: AW] = a;
   endtask

   task automatic model_clear();
      for (int i = 0; i < D; i++) mreg[i] = '0;
      mpend = '0;
   endtask

   // Reference update from the currently driven inputs, applied at the next edge.
   task automatic model_edge();
      for (int i = 1; i < D; i++) begin
         logic h0, h1, hr;
         h0 = wb0_en && wb0_addr == AW'(i);
         h1 = wb1_en && wb1_addr == AW'(i);
         hr = rsv_en && rsv_addr == AW'(i);
         if (h1) mreg[i] = wb1_data;
         else if (h0) mreg[i] = wb0_data;
         if (hr) mpend[i] = 1'b1;
         else if (h0 || h1) mpend[i] = 1'b0;
      end
   endtask

   // Expected combinational read for the currently driven inputs.
   task automatic model_rd(input logic [AW-1:0] a, output logic [W-1:0] d, output logic b);
      d = mreg[a];
      b = mpend[a];
`ifdef REG_FILE_BYPASS_EN
      if (wb0_en && wb0_addr == a) begin d = wb0_data; b = rsv_en && rsv_addr == a; end
      if (wb1_en && wb1_addr == a) begin d = wb1_data; b = rsv_en && rsv_addr == a; end
`endif
      if (a == '0) begin d = '0; b = 1'b0; end
   endtask

   task automatic cyc();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   task automatic test_reset();
      exp_t e;
      idle();
      rd_addr = '0;
      rst = 1;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      set_rd(0, 5); set_rd(1, 31);
      #1;
      push("reset_r5", 0, '0, 0);
      push("reset_r31", 1, '0, 0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
            $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
         else n_pass++;
      end
      n_chk++;
      if (pending !== '0) $display("FAIL reset_pending: got %h, expected 0", pending);
      else n_pass++;
   endtask

   task automatic test_r0();
      exp_t e;
      wb0_en = 1; wb0_addr = 0; wb0_data = 32'hDEADBEEF;
      rsv_en = 1; rsv_addr = 0;
      cyc();
      set_rd(0, 0); set_rd(1, 0);
      #1;
      push("r0_p0", 0, '0, 0);
      push("r0_p1", 1, '0, 0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
            $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
         else n_pass++;
      end
      n_chk++;
      if (pending !== '0) $display("FAIL r0_pending: got %h, expected 0", pending);
      else n_pass++;
   endtask

   task automatic test_write();
      exp_t e;
      set_rd(0, 7); set_rd(1, 7);
      wb0_en = 1; wb0_addr = 7; wb0_data = 32'h12345678;
      #1;
`ifdef REG_FILE_BYPASS_EN
      push("wr_same_cyc", 0, 32'h12345678, 0);
      push("wr_same_cyc", 1, 32'h12345678, 0);
`else
      push("wr_same_cyc", 0, 32'h0, 0);
      push("wr_same_cyc", 1, 32'h0, 0);
`endif
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
            $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
         else n_pass++;
      end
      cyc();
      #1;
      push("wr_next_cyc", 0, 32'h12345678, 0);
      push("wr_next_cyc", 1, 32'h12345678, 0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
            $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
         else n_pass++;
      end
   endtask

   task automatic test_scoreboard();
      exp_t e;
      set_rd(0, 3); set_rd(1, 3);
      rsv_en = 1; rsv_addr = 3;
      cyc();
      for (int c = 1; c <= 3; c++) begin
         #1;
         push($sformatf("sb_busy_n%0d", c), 0, '0, 1);
         push($sformatf("sb_busy_n%0d", c), 1, '0, 1);
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_chk++;
            if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
               $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                        e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
            else n_pass++;
         end
         cyc();
      end
      wb1_en = 1; wb1_addr = 3; wb1_data = 32'hA5A5A5A5;
      cyc();
      #1;
      push("sb_done", 0, 32'hA5A5A5A5, 0);
      push("sb_done", 1, 32'hA5A5A5A5, 0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
            $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
         else n_pass++;
      end
   endtask

   task automatic test_collide();
      exp_t e;
      rsv_en = 1; rsv_addr = 9;
      wb0_en = 1; wb0_addr = 9; wb0_data = 32'h1;
      cyc();
      wb0_en = 1; wb0_addr = 4; wb0_data = 32'h11;
      wb1_en = 1; wb1_addr = 4; wb1_data = 32'h22;
      cyc();
      set_rd(0, 9); set_rd(1, 4);
      #1;
      push("rsv_wins_r9", 0, 32'h1, 1);
      push("wb1_wins_r4", 1, 32'h22, 0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
            $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
         else n_pass++;
      end
      n_chk++;
      if (pending !== 32'h0000_0200) $display("FAIL collide_pending: got %h, expected %h", pending, 32'h0000_0200);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      exp_t e;
      rsv_en = 1; rsv_addr = 10;
      wb0_en = 1; wb0_addr = 10; wb0_data = 32'h55;
      cyc();
      set_rd(0, 10); set_rd(1, 9);
      #1;
      push("pre_rst_r10", 0, 32'h55, 1);
      push("pre_rst_r9", 1, 32'h1, 1);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
            $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
         else n_pass++;
      end
      wb1_en = 1; wb1_addr = 10; wb1_data = 32'h99;
      #1;
      rst = 1;
      #1;
      model_clear();
      push("in_rst_r10", 0, '0, 0);
      push("in_rst_r9", 1, '0, 0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
            $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
         else n_pass++;
      end
      n_chk++;
      if (pending !== '0) $display("FAIL async_rst_pending: got %h, expected 0", pending);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      idle();
      #1;
      push("post_rst_r10", 0, '0, 0);
      push("post_rst_r9", 1, '0, 0);
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         n_chk++;
         if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
            $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                     e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      exp_t         e;
      logic [W-1:0] d;
      logic         b;
      for (int c = 0; c < 60; c++) begin
         wb0_en   = 1'($urandom_range(0, 1));
         wb0_addr = AW'($urandom_range(0, 7));
         wb0_data = $urandom;
         wb1_en   = 1'($urandom_range(0, 3) == 0);
         wb1_addr = AW'($urandom_range(0, 7));
         wb1_data = $urandom;
         rsv_en   = 1'($urandom_range(0, 1));
         rsv_addr = AW'($urandom_range(0, 7));
         for (int k = 0; k < NR; k++) set_rd(k, AW'($urandom_range(0, 7)));
         #1;
         for (int k = 0; k < NR; k++) begin
            model_rd(rd_addr[k*AW +: AW], d, b);
            push($sformatf("rand_c%0d", c), k, d, b);
         end
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_chk++;
            if (rd_data[e.port*W +: W] !== e.data || rd_busy[e.port] !== e.busy)
               $display("FAIL %s port%0d: got data=%h busy=%b, expected data=%h busy=%b",
                        e.name, e.port, rd_data[e.port*W +: W], rd_busy[e.port], e.data, e.busy);
            else n_pass++;
         end
         n_chk++;
         if (pending !== mpend) $display("FAIL rand_pending_c%0d: got %h, expected %h", c, pending, mpend);
         else n_pass++;
         cyc();
      end
   endtask

   initial begin
      rst = 1;
      idle();
      rd_addr = '0;
      model_clear();
      test_reset();
      test_r0();
      test_write();
      test_scoreboard();
      test_collide();
      test_async_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
